// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sequencing one shared ALU among NUM_REQ requesters, one op in flight.
// Latency: grant at T, alu_* at T+1, rsp_valid at T+2; holds in RESP until rsp_ready[id], no timeout.
module alu_share_arbiter #(
  parameter  int WIDTH   = 32,
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*3-1:0]     req_op,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [2:0]               alu_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_zero,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_zero,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } alu_req_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cur_id;
  logic [IDW-1:0] win_id;
  logic           win_vld;
  alu_req_t       req_arr [NUM_REQ];
  alu_req_t       win_dat;

  // Explicit wrap keeps the pointer legal for non-power-of-2 NUM_REQ.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id == IDW'(NUM_REQ - 1)) ? '0 : id + IDW'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [IDW-1:0] id);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_arr[i].op = req_op[3*i +: 3];
    assign req_arr[i].a  = req_a[WIDTH*i +: WIDTH];
    assign req_arr[i].b  = req_b[WIDTH*i +: WIDTH];
  end

  // First valid requester at or after rr_ptr, walking upward with wrap.
  always_comb begin
    logic [IDW-1:0] idx;
    idx     = rr_ptr;
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_vld && req_valid[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
      idx = next_id(idx);
    end
  end

  assign win_dat   = req_arr[win_id];
  assign req_ready = (state == IDLE && !rst && win_vld) ? id_onehot(win_id) : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_id     <= '0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            alu_op <= win_dat.op;
            alu_a  <= win_dat.a;
            alu_b  <= win_dat.b;
            cur_id <= win_id;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= id_onehot(cur_id);
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready[cur_id]) begin
            rsp_valid <= '0;
            rr_ptr    <= next_id(cur_id);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));
  a_no_grant_busy: assert property (@(posedge clk) disable iff (rst) busy |-> (req_ready == '0));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed checks of alu_share_arbiter against a transaction-level model.
module tb_alu_share_arbiter;
  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*3-1:0] req_op = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [2:0]     alu_op;
  logic [W-1:0]   alu_a, alu_b, alu_result, rsp_result;
  logic           alu_zero, rsp_zero, busy;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '0;

  alu_share_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared combinational ALU standing in for the real datapath.
  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction
  assign alu_result = alu_fn(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester-side stimulus state
  logic [N-1:0] pend;
  logic [N-1:0] rrdy;
  logic [2:0]   opv [N];
  logic [W-1:0] av [N];
  logic [W-1:0] bv [N];
  logic [2:0]   ops [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
  int           exp_order [5] = '{0, 1, 2, 3, 0};

  // Transaction-level reference state
  int           cyc;
  int           last_served;
  bit           inflight;
  int           exp_id;
  int           gcyc;
  logic [2:0]   m_op;
  logic [W-1:0] m_a, m_b, m_res;
  logic         m_zero;
  logic [N-1:0] m_rspv;
  int           gq [$];
  int           gcq [$];

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last_served + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive();
    req_valid = pend;
    rsp_ready = rrdy;
    for (int i = 0; i < N; i++) begin
      req_op[3*i +: 3] = opv[i];
      req_a[W*i +: W]  = av[i];
      req_b[W*i +: W]  = bv[i];
    end
  endtask

  task automatic sample();
    int w;
    w = inflight ? -1 : pick(req_valid);
    chk_eq("req_ready", req_ready, (w >= 0) ? (64'd1 << w) : 64'd0);
    chk_eq("alu_op", alu_op, m_op);
    chk_eq("alu_a", alu_a, m_a);
    chk_eq("alu_b", alu_b, m_b);
    chk_eq("rsp_valid", rsp_valid, m_rspv);
    chk_eq("rsp_result", rsp_result, m_res);
    chk_eq("rsp_zero", rsp_zero, m_zero);
    chk_eq("busy", busy, inflight);
    if (inflight && cyc == gcyc + 1) begin
      m_res  = alu_fn(m_op, m_a, m_b);
      m_zero = (m_res == '0);
      m_rspv = N'(1) << exp_id;
    end else if (inflight && cyc >= gcyc + 2 && rsp_ready[exp_id]) begin
      m_rspv      = '0;
      inflight    = 1'b0;
      last_served = exp_id;
    end
    if (w >= 0) begin
      inflight = 1'b1;
      exp_id   = w;
      gcyc     = cyc;
      m_op     = opv[w];
      m_a      = av[w];
      m_b      = bv[w];
      pend[w]  = 1'b0;
      gq.push_back(w);
      gcq.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    drive();
    #2;
    sample();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive();
    #2;
    chk_eq("rst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    chk_eq("rst_alu_op", alu_op, 0);
    chk_eq("rst_alu_a", alu_a, 0);
    chk_eq("rst_alu_b", alu_b, 0);
    chk_eq("rst_rsp_valid", rsp_valid, 0);
    chk_eq("rst_rsp_result", rsp_result, 0);
    chk_eq("rst_rsp_zero", rsp_zero, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_req_ready2", req_ready, 0);
    rst         = 1'b0;
    inflight    = 1'b0;
    last_served = N - 1;
    m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_zero = 1'b0; m_rspv = '0;
    drive();
    #2;
    sample();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      opv[i] = '0; av[i] = '0; bv[i] = '0;
    end
    pend = '0; rrdy = '0; cyc = 0; inflight = 1'b0; last_served = N - 1;
    exp_id = 0; gcyc = 0;
    m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_zero = 1'b0; m_rspv = '0;
    do_reset();

    // Single request: add 5+7 from requester 1
    opv[1] = 3'b010; av[1] = 5; bv[1] = 7; pend = 4'b0010; rrdy = '0;
    cycle();
    chk_eq("t1_grant", req_ready, 4'b0010);
    cycle();
    chk_eq("t1_alu_a", alu_a, 5);
    chk_eq("t1_alu_b", alu_b, 7);
    cycle();
    chk_eq("t1_rsp_valid", rsp_valid, 4'b0010);
    chk_eq("t1_result", rsp_result, 12);
    chk_eq("t1_zero", rsp_zero, 0);
    rrdy = '1;
    cycle();
    cycle();
    chk_eq("t1_idle", busy, 0);

    // Zero flag from equal-operand subtract
    opv[0] = 3'b110; av[0] = 32'h1234; bv[0] = 32'h1234; pend = 4'b0001;
    repeat (3) cycle();
    chk_eq("t2_rsp_valid", rsp_valid, 4'b0001);
    chk_eq("t2_result", rsp_result, 0);
    chk_eq("t2_zero", rsp_zero, 1);
    cycle();

    // Round robin with all requests held
    do_reset();
    for (int i = 0; i < N; i++) begin
      opv[i] = 3'b010; av[i] = 10 * i; bv[i] = 1;
    end
    rrdy = '1;
    gq.delete(); gcq.delete();
    repeat (14) begin
      pend = '1;
      cycle();
    end
    chk_eq("t3_count", gq.size(), 5);
    for (int k = 0; k < 5; k++)
      chk_eq("t3_order", (gq.size() > k) ? gq[k] : -1, exp_order[k]);
    for (int k = 1; k < 5; k++)
      chk_eq("t3_gap", (gcq.size() > k) ? gcq[k] - gcq[k-1] : -1, 3);

    // Wrap and skip: serve 2 first, then 0/1, with 3 arriving late
    do_reset();
    pend = 4'b0100;
    repeat (4) cycle();
    gq.delete();
    pend = 4'b0011;
    repeat (2) cycle();
    pend = pend | 4'b1000;
    repeat (10) cycle();
    chk_eq("t4_count", gq.size(), 3);
    chk_eq("t4_g0", (gq.size() > 0) ? gq[0] : -1, 0);
    chk_eq("t4_g1", (gq.size() > 1) ? gq[1] : -1, 1);
    chk_eq("t4_g2", (gq.size() > 2) ? gq[2] : -1, 3);

    // Response stall with competing requests
    gq.delete();
    rrdy = '0;
    opv[2] = 3'b001; av[2] = 32'hF0; bv[2] = 32'h0F; pend = 4'b0100;
    cycle();
    pend = pend | 4'b1001;
    repeat (7) cycle();
    chk_eq("t5_busy", busy, 1);
    chk_eq("t5_rsp_valid", rsp_valid, 4'b0100);
    chk_eq("t5_result", rsp_result, 32'hFF);
    chk_eq("t5_ready", req_ready, 0);
    rrdy = '1;
    repeat (10) cycle();
    chk_eq("t5_count", gq.size(), 3);
    chk_eq("t5_g0", (gq.size() > 0) ? gq[0] : -1, 2);
    chk_eq("t5_g1", (gq.size() > 1) ? gq[1] : -1, 3);
    chk_eq("t5_g2", (gq.size() > 2) ? gq[2] : -1, 0);

    // Reset during EXEC, then during RESP
    rrdy = '0;
    pend = 4'b0100;
    cycle();
    do_reset();
    pend = '0;
    repeat (3) cycle();
    chk_eq("t6_no_rsp", rsp_valid, 0);
    pend = 4'b1000;
    repeat (3) cycle();
    chk_eq("t6_resp", rsp_valid, 4'b1000);
    do_reset();
    chk_eq("t6_no_rsp2", rsp_valid, 0);
    gq.delete();
    pend = '1;
    cycle();
    chk_eq("t6_first", (gq.size() > 0) ? gq[0] : -1, 0);
    rrdy = '1;
    repeat (4) cycle();

    // Randomized traffic with random response backpressure and rare resets
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          opv[i]  = ops[$urandom_range(0, 4)];
          av[i]   = $urandom;
          bv[i]   = ($urandom_range(0, 3) == 0) ? av[i] : $urandom;
        end
      end
      rrdy = N'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
